countdown_timer: RTL and testbench

Programmable down-counting timer with prescaler, one-shot/auto-reload modes and a terminal-count pulse. It complements the free-running 4-bit up counter. Where the up counter measures elapsed cycles from reset, this block counts a loaded value down to zero and signals expiry. It sits beside the counter in the timing/control path as the timeout and periodic-tick source.

---
 rtl/countdown_timer.sv | 106 ++++++++++
 tb/tb_countdown_timer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaler, one-shot or
// auto-reload modes, and a one-cycle terminal-count pulse.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start, stop     (re)start counting / abort to idle; stop wins
//   en              count enable, low freezes prescaler and count
//   reload          auto-reload select, latched on start
//   presc           tick every presc+1 enabled clocks, latched on start
//   load_val        initial count, latched on start
//   count           current count value
//   tc              terminal-count pulse, one cycle wide
//   busy            high while counting
//   done            high once a one-shot count has expired
module countdown_timer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic               reload,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   reload_val;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt;
    logic               reload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reload_val <= '0;
            presc_q    <= '0;
            reload_q   <= 1'b0;
            pcnt       <= '0;
        end else begin
            // tc is a pulse: only the expiring/reloading edge raises it
            tc <= 1'b0;
            if (stop) begin
                // count keeps whatever value it had when aborted
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                reload_val <= load_val;
                presc_q    <= presc;
                reload_q   <= reload;
                pcnt       <= '0;
                if (load_val != '0) begin
                    count <= load_val;
                    state <= RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end else begin
                    // a zero load expires at once, even in reload mode
                    count <= '0;
                    tc    <= 1'b1;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (state == RUN && en) begin
                if (pcnt == presc_q) begin
                    pcnt <= '0;
                    if (count > WIDTH'(1)) begin
                        count <= count - WIDTH'(1);
                    end else if (count == WIDTH'(1)) begin
                        tc <= 1'b1;
                        if (reload_q) begin
                            // reload skips zero so the period stays N ticks
                            count <= reload_val;
                        end else begin
                            count <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end else begin
                    pcnt <= pcnt + PRESC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and randomized checks of countdown_timer
// against an elapsed-cycle reference model.
module tb_countdown_timer;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               en;
    logic               reload;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               busy;
    logic               done;

    int tests;
    int fails;

    // reference model: mode 0 idle, 1 run, 2 expired
    int m_mode;
    int m_n;
    int m_p;
    int m_r;
    int m_e;
    int m_count;
    int m_tc;

    countdown_timer #(
        .WIDTH  (WIDTH),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .en      (en),
        .reload  (reload),
        .presc   (presc),
        .load_val(load_val),
        .count   (count),
        .tc      (tc),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] model_out();
        logic [10:0] v;
        v = {m_count[WIDTH-1:0], m_tc[0], m_mode == 1, m_mode == 2};
        return v;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_n     = 0;
        m_p     = 0;
        m_r     = 0;
        m_e     = 0;
        m_count = 0;
        m_tc    = 0;
    endtask

    // Advance the model by one edge, from the inputs being applied.
    // Count is derived from elapsed enabled cycles since start.
    task automatic model_edge();
        int ticks;
        bit tick_now;
        m_tc = 0;
        if (stop) begin
            m_mode = 0;
        end else if (start) begin
            m_n = int'(load_val);
            m_p = int'(presc);
            m_r = int'(reload);
            m_e = 0;
            if (m_n == 0) begin
                m_count = 0;
                m_tc    = 1;
                m_mode  = 2;
            end else begin
                m_count = m_n;
                m_mode  = 1;
            end
        end else if (m_mode == 1 && en) begin
            m_e      = m_e + 1;
            ticks    = m_e / (m_p + 1);
            tick_now = (m_e % (m_p + 1)) == 0;
            if (m_r != 0) begin
                m_count = m_n - (ticks % m_n);
                m_tc    = (tick_now && ticks % m_n == 0) ? 1 : 0;
            end else if (ticks >= m_n) begin
                m_count = 0;
                m_tc    = 1;
                m_mode  = 2;
            end else begin
                m_count = m_n - ticks;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        stop     = 1'b0;
        en       = 1'b1;
        reload   = 1'b0;
        presc    = '0;
        load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        tests++;
        if ({count, tc, busy, done} !== 11'd0) begin
            fails++;
            $display("FAIL reset_state: got %h/%b/%b/%b want 0/0/0/0",
                     count, tc, busy, done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        tests++;
        if ({count, tc, busy, done} !== model_out()) begin
            fails++;
            $display("FAIL reset_release: got %h/%b/%b/%b want %h",
                     count, tc, busy, done, model_out());
        end
    endtask

    task automatic test_async_reset();
        load_val = 8'h37;
        en       = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        tests++;
        if (count !== 8'h37 || busy !== 1'b1) begin
            fails++;
            $display("FAIL async_setup: got count=%h busy=%b want 37/1",
                     count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({count, tc, busy, done} !== 11'd0) begin
            fails++;
            $display("FAIL async_reset: got %h/%b/%b/%b want 0/0/0/0",
                     count, tc, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({count, tc, busy, done} !== 11'd0) begin
                fails++;
                $display("FAIL async_after: got %h/%b/%b/%b want 0",
                         count, tc, busy, done);
            end
        end
    endtask

    task automatic test_oneshot();
        idle_inputs();
        load_val = 8'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tests++;
            if (k <= 5 && (count !== 8'(5 - k) || tc !== (k == 5))) begin
                fails++;
                $display("FAIL oneshot_seq k=%0d: got %0d tc=%b want %0d tc=%b",
                         k, count, tc, 5 - k, k == 5);
            end
            tests++;
            if ({count, tc, busy, done} !== model_out()) begin
                fails++;
                $display("FAIL oneshot_model k=%0d: got %h want %h",
                         k, {count, tc, busy, done}, model_out());
            end
            step();
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            fails++;
            $display("FAIL oneshot_hold: got done=%b busy=%b count=%0d",
                     done, busy, count);
        end
    endtask

    task automatic test_prescaler();
        int tc_at;
        idle_inputs();
        load_val = 8'd3;
        presc    = 4'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        tc_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tc === 1'b1 && tc_at < 0) tc_at = k;
            tests++;
            if ({count, tc, busy, done} !== model_out()) begin
                fails++;
                $display("FAIL presc_model k=%0d: got %h want %h",
                         k, {count, tc, busy, done}, model_out());
            end
        end
        tests++;
        if (tc_at != 9) begin
            fails++;
            $display("FAIL presc_expiry: got tc at %0d want 9", tc_at);
        end
    endtask

    task automatic test_reload();
        int pulses;
        logic [WIDTH-1:0] held;
        idle_inputs();
        load_val = 8'd4;
        reload   = 1'b1;
        start    = 1'b1;
        step();
        start  = 1'b0;
        reload = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (tc === 1'b1) pulses++;
            tests++;
            if (count !== 8'(4 - (k % 4)) || tc !== (k % 4 == 0)
                || busy !== 1'b1) begin
                fails++;
                $display("FAIL reload_seq k=%0d: got %0d tc=%b busy=%b",
                         k, count, tc, busy);
            end
        end
        tests++;
        if (pulses != 3) begin
            fails++;
            $display("FAIL reload_pulses: got %0d want 3", pulses);
        end
        held = count;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        tests++;
        if (count !== held || busy !== 1'b0 || tc !== 1'b0) begin
            fails++;
            $display("FAIL reload_stop: got %0d busy=%b want %0d busy=0",
                     count, busy, held);
        end
    endtask

    task automatic test_pause_priority();
        int tc_at;
        logic [WIDTH-1:0] held;
        idle_inputs();
        load_val = 8'd6;
        start    = 1'b1;
        step();
        start = 1'b0;
        tc_at = -1;
        for (int k = 1; k <= 11; k++) begin
            en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            step();
            if (tc === 1'b1 && tc_at < 0) tc_at = k;
            tests++;
            if ({count, tc, busy, done} !== model_out()) begin
                fails++;
                $display("FAIL pause_model k=%0d: got %h want %h",
                         k, {count, tc, busy, done}, model_out());
            end
        end
        tests++;
        if (tc_at != 9) begin
            fails++;
            $display("FAIL pause_expiry: got tc at %0d want 9", tc_at);
        end
        en       = 1'b1;
        load_val = 8'd9;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        held     = count;
        load_val = 8'd20;
        start    = 1'b1;
        stop     = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        tests++;
        if (count !== held || busy !== 1'b0 || tc !== 1'b0) begin
            fails++;
            $display("FAIL start_stop: got %0d busy=%b tc=%b want %0d/0/0",
                     count, busy, tc, held);
        end
        load_val = 8'd0;
        start    = 1'b1;
        step();
        load_val = 8'd7;
        step();
        start = 1'b0;
        tests++;
        if (count !== 8'd7 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_done: got %0d busy=%b done=%b want 7/1/0",
                     count, busy, done);
        end
    endtask

    task automatic test_zero_load();
        for (int r = 0; r < 2; r++) begin
            idle_inputs();
            stop = 1'b1;
            step();
            stop     = 1'b0;
            load_val = 8'd0;
            reload   = 1'(r);
            start    = 1'b1;
            step();
            start = 1'b0;
            tests++;
            if (tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0
                || count !== 8'd0) begin
                fails++;
                $display("FAIL zero_load r=%0d: got tc=%b done=%b busy=%b %0d",
                         r, tc, done, busy, count);
            end
            for (int k = 0; k < 3; k++) begin
                step();
                tests++;
                if (tc !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                    fails++;
                    $display("FAIL zero_hold r=%0d: got tc=%b busy=%b done=%b",
                             r, tc, busy, done);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 3) != 0);
            reload   = 1'($urandom_range(0, 1));
            presc    = PRESC_W'($urandom_range(0, 3));
            load_val = ($urandom_range(0, 7) == 0) ? 8'd0
                       : WIDTH'($urandom_range(1, 12));
            step();
            tests++;
            if ({count, tc, busy, done} !== model_out()) begin
                fails++;
                $display("FAIL random k=%0d: got %h/%b/%b/%b want %h",
                         k, count, tc, busy, done, model_out());
            end
            tests++;
            if (busy === 1'b1 && done === 1'b1) begin
                fails++;
                $display("FAIL busy_done_excl k=%0d: got both 1 want exclusive",
                         k);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_async_reset();
        test_oneshot();
        test_prescaler();
        test_reload();
        test_pause_priority();
        test_zero_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
